pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Program-counter register and instruction-fetch sequencer for the 16-bit multicycle datapath.
//  Holds PC, drives instruction-memory request/ack handshake, latches IR.
//  Consumes the 16-bit output of the 5:1 PC-source mux (pc_next).
//  Supplies pc_plus2 back as that mux's sequential-PC input.
// PARAMETERS
//  RESET_PC  16'h0000  PC value loaded on reset
//  TIMEOUT   8'd255    cycles in FETCH without mem_ack before bus_err (1..255)
// PORTS
//  CLK            in   1   clock, rising edge
//  Reset          in   1   asynchronous, active-high reset
//  pc_next        in   16  next-PC value from PC-source mux
//  pc_write       in   1   unconditional PC load request
//  pc_write_cond  in   1   PC load request qualified by zero
//  zero           in   1   ALU zero flag
//  fetch_start    in   1   begin instruction fetch at current PC (accepted in IDLE only)
//  mem_rdata      in   16  instruction word from memory
//  mem_ack        in   1   memory read complete; mem_rdata valid this cycle
//  pc             out  16  current PC
//  pc_plus2       out  16  pc + 2, modulo 2^16, combinational
//  mem_addr       out  16  fetch address (= pc while mem_req = 1, else pc)
//  mem_req        out  1   read request, held until ack or timeout
//  ir             out  16  instruction register
//  ir_valid       out  1   1-cycle pulse: ir updated
//  busy           out  1   1 in FETCH or DONE
//  misalign_err   out  1   1-cycle pulse: fetch refused, odd address
//  bus_err        out  1   1-cycle pulse: fetch timed out
// BEHAVIOUR
//  Reset (async): pc = RESET_PC; ir = 0; state = IDLE; pending = 0; timer = 0.
//    All pulse outputs = 0; mem_req = 0.
//  pc_load = pc_write | (pc_write_cond & zero).
//  States:
//  - IDLE: busy = 0.
//    - pc_load: pc <= pc_next at the edge.
//    - fetch_start: fetch address tgt = (pc_load ? pc_next : pc).
//      - tgt[0] = 1: misalign_err = 1 next cycle; stay IDLE.
//      - otherwise: -> FETCH.
//  - FETCH: mem_req = 1; mem_addr = pc, stable; timer increments each cycle.
//    - mem_ack = 1: ir <= mem_rdata -> DONE; timer <= 0.
//    - timer == TIMEOUT-1 and no ack: bus_err = 1 next cycle; -> IDLE; ir unchanged; timer <= 0.
//    - ack on the timeout cycle: ack wins, no bus_err.
//  - DONE (1 cycle): ir_valid = 1; mem_req = 0 -> IDLE.
//    - Any pending PC load is applied at this edge.
//  Loads during FETCH/DONE:
//    - pc_load is never applied immediately (fetch address must stay stable).
//    - Captured into pending reg (value + flag); last request wins.
//    - A pc_load in the DONE cycle itself overrides the pending value.
//    - On bus_err exit, pending load is also applied.
//  fetch_start while busy: ignored (not queued).
//  pc wraps 16'hFFFE + 2 -> 16'h0000; no flag.
//  Latency: fetch_start at edge t -> mem_req high t+1.
//    Ack sampled at edge k -> ir/ir_valid at k+1 -> IDLE at k+2; min 3 cycles per fetch.
//  Reset mid-FETCH: mem_req drops immediately (async); pending load discarded.
// TESTING
//  1. Reset, RESET_PC=0 -> pc=0, mem_req=0, ir=0; fetch_start, ack after 2 cycles with rdata=16'h1234
//     -> mem_addr=0 while req; ir=16'h1234, ir_valid 1 cycle.
//  2. pc_write with pc_next=16'h0040 during FETCH, ack later
//     -> pc stays 0 until DONE edge, then 16'h0040; mem_addr=0 throughout.
//  3. IDLE: pc_write_cond=1, zero=0 -> pc unchanged; zero=1, pc_next=16'h0100 -> pc=16'h0100.
//  4. fetch_start with pc_write, pc_next=16'h0003 same cycle -> misalign_err pulse, mem_req stays 0.
//  5. TIMEOUT=4, no ack -> mem_req high exactly 4 cycles, bus_err pulse, ir unchanged, busy=0.
//  6. pc=16'hFFFE -> pc_plus2=16'h0000; Reset asserted mid-FETCH -> mem_req=0 same cycle, pc=RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch sequencer for the 16-bit multicycle datapath.
// Owns PC and IR and runs the memory req/ack handshake with a timeout.
module pc_fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [7:0]  TIMEOUT  = 8'd255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [15:0] pc_next_i,
   input  logic        pc_write_i,
   input  logic        pc_write_cond_i,
   input  logic        zero_i,
   input  logic        fetch_start_i,
   input  logic [15:0] mem_rdata_i,
   input  logic        mem_ack_i,
   output logic [15:0] pc_o,
   output logic [15:0] pc_plus2_o,
   output logic [15:0] mem_addr_o,
   output logic        mem_req_o,
   output logic [15:0] ir_o,
   output logic        ir_valid_o,
   output logic        busy_o,
   output logic        misalign_err_o,
   output logic        bus_err_o
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] ir_q, ir_d;
   logic [15:0] pend_pc_q, pend_pc_d;
   logic        pend_vld_q, pend_vld_d;
   logic [7:0]  timer_q, timer_d;
   logic        misalign_q, misalign_d;
   logic        bus_err_q, bus_err_d;

   logic        pc_load;
   logic [15:0] fetch_tgt;

   assign pc_load   = pc_write_i | (pc_write_cond_i & zero_i);
   assign fetch_tgt = pc_load ? pc_next_i : pc_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         ir_q       <= 16'h0000;
         pend_pc_q  <= 16'h0000;
         pend_vld_q <= 1'b0;
         timer_q    <= 8'd0;
         misalign_q <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         pend_pc_q  <= pend_pc_d;
         pend_vld_q <= pend_vld_d;
         timer_q    <= timer_d;
         misalign_q <= misalign_d;
         bus_err_q  <= bus_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      pend_pc_d  = pend_pc_q;
      pend_vld_d = pend_vld_q;
      timer_d    = timer_q;
      misalign_d = 1'b0;
      bus_err_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (pc_load) pc_d = pc_next_i;
            if (fetch_start_i) begin
               if (fetch_tgt[0]) begin
                  misalign_d = 1'b1;
               end else begin
                  state_d = S_FETCH;
                  timer_d = 8'd0;
               end
            end
         end
         S_FETCH: begin
            // PC must hold the fetch address, so loads are parked until exit.
            if (pc_load) begin
               pend_pc_d  = pc_next_i;
               pend_vld_d = 1'b1;
            end
            if (mem_ack_i) begin
               ir_d    = mem_rdata_i;
               state_d = S_DONE;
               timer_d = 8'd0;
            end else if (timer_q == TIMEOUT - 8'd1) begin
               bus_err_d  = 1'b1;
               state_d    = S_IDLE;
               timer_d    = 8'd0;
               pend_vld_d = 1'b0;
               if (pc_load)         pc_d = pc_next_i;
               else if (pend_vld_q) pc_d = pend_pc_q;
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
         S_DONE: begin
            state_d    = S_IDLE;
            pend_vld_d = 1'b0;
            if (pc_load)         pc_d = pc_next_i;
            else if (pend_vld_q) pc_d = pend_pc_q;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign pc_o           = pc_q;
   assign pc_plus2_o     = pc_q + 16'd2;
   assign mem_addr_o     = pc_q;
   assign mem_req_o      = (state_q == S_FETCH);
   assign ir_o           = ir_q;
   assign ir_valid_o     = (state_q == S_DONE);
   assign busy_o         = (state_q != S_IDLE);
   assign misalign_err_o = misalign_q;
   assign bus_err_o      = bus_err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit; fetched words go through an expected-IR queue
// that a negedge monitor drains whenever ir_valid is seen.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] pc_next;
   logic        pc_write, pc_write_cond, zero, fetch_start, mem_ack;
   logic [15:0] mem_rdata;
   logic [15:0] pc, pc_plus2, mem_addr, ir;
   logic        mem_req, ir_valid, busy, misalign_err, bus_err;

   int vectors     = 0;
   int miscompares = 0;
   logic [15:0] exp_ir_q[$];
   logic [15:0] exp_ir;
   int n_req;

   pc_fetch_unit #(.RESET_PC(16'h0000), .TIMEOUT(8'd4)) dut (
      .clk_i(clk), .rst_i(rst), .pc_next_i(pc_next), .pc_write_i(pc_write),
      .pc_write_cond_i(pc_write_cond), .zero_i(zero), .fetch_start_i(fetch_start),
      .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack), .pc_o(pc), .pc_plus2_o(pc_plus2),
      .mem_addr_o(mem_addr), .mem_req_o(mem_req), .ir_o(ir), .ir_valid_o(ir_valid),
      .busy_o(busy), .misalign_err_o(misalign_err), .bus_err_o(bus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard drain: every ir_valid pulse must match the oldest expected word.
   always @(negedge clk) begin
      if (ir_valid === 1'b1) begin
         if (exp_ir_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL ir_unexpected observed=%0h expected=none", ir);
         end else begin
            exp_ir = exp_ir_q.pop_front();
            chk("ir_sb", {16'h0, ir}, {16'h0, exp_ir});
         end
      end
   end

   initial begin
      rst = 1'b1; pc_next = 16'h0; pc_write = 0; pc_write_cond = 0; zero = 0;
      fetch_start = 0; mem_ack = 0; mem_rdata = 16'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_pc", pc, 16'h0000);
      chk("rst_req", mem_req, 0);
      chk("rst_ir", ir, 16'h0000);
      chk("rst_busy", busy, 0);
      rst = 1'b0;

      // 1: basic fetch, ack in second FETCH cycle
      tick();
      fetch_start = 1;
      tick();
      fetch_start = 0;
      @(negedge clk);
      chk("t1_req0", mem_req, 1);
      chk("t1_addr0", mem_addr, 16'h0000);
      tick();
      chk("t1_req1", mem_req, 1);
      mem_ack = 1; mem_rdata = 16'h1234;
      exp_ir_q.push_back(16'h1234);
      tick();
      mem_ack = 0;
      @(negedge clk);
      chk("t1_done_req", mem_req, 0);
      chk("t1_done_busy", busy, 1);
      tick();
      @(negedge clk);
      chk("t1_ivld_off", ir_valid, 0);
      chk("t1_ir_hold", ir, 16'h1234);
      chk("t1_idle", busy, 0);

      // 2: pc_write during FETCH is deferred to the DONE edge
      fetch_start = 1;
      tick();
      fetch_start = 0; pc_write = 1; pc_next = 16'h0040;
      @(negedge clk);
      chk("t2_pc_f0", pc, 16'h0000);
      tick();
      pc_write = 0;
      chk("t2_pc_f1", pc, 16'h0000);
      chk("t2_addr_f1", mem_addr, 16'h0000);
      mem_ack = 1; mem_rdata = 16'hABCD;
      exp_ir_q.push_back(16'hABCD);
      tick();
      mem_ack = 0;
      @(negedge clk);
      chk("t2_pc_done", pc, 16'h0000);
      tick();
      chk("t2_pc_after", pc, 16'h0040);

      // 3: conditional write qualified by zero
      pc_write_cond = 1; zero = 0; pc_next = 16'h0100;
      tick();
      chk("t3_cond_z0", pc, 16'h0040);
      zero = 1;
      tick();
      pc_write_cond = 0; zero = 0;
      chk("t3_cond_z1", pc, 16'h0100);
      chk("t3_plus2", pc_plus2, 16'h0102);

      // 4: odd fetch target from same-cycle load
      fetch_start = 1; pc_write = 1; pc_next = 16'h0003;
      @(negedge clk);
      chk("t4_mis_early", misalign_err, 0);
      tick();
      fetch_start = 0; pc_write = 0;
      @(negedge clk);
      chk("t4_mis", misalign_err, 1);
      chk("t4_req", mem_req, 0);
      chk("t4_busy", busy, 0);
      tick();
      chk("t4_mis_pulse", misalign_err, 0);
      pc_write = 1; pc_next = 16'h0200;
      tick();
      pc_write = 0;

      // 5: timeout after 4 FETCH cycles, pending load applied on exit
      fetch_start = 1;
      tick();
      fetch_start = 0; pc_write = 1; pc_next = 16'h0300;
      n_req = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (mem_req !== 1'b1) break;
         n_req++;
         chk("t5_addr", mem_addr, 16'h0200);
         tick();
         pc_write = 0;
      end
      chk("t5_req_cycles", n_req, 4);
      chk("t5_bus_err", bus_err, 1);
      chk("t5_busy", busy, 0);
      chk("t5_ir", ir, 16'hABCD);
      chk("t5_pc_pend", pc, 16'h0300);
      tick();
      chk("t5_berr_pulse", bus_err, 0);

      // 6: wrap of pc_plus2, async reset mid-FETCH discards pending load
      pc_write = 1; pc_next = 16'hFFFE;
      tick();
      pc_write = 0;
      chk("t6_pc", pc, 16'hFFFE);
      chk("t6_wrap", pc_plus2, 16'h0000);
      fetch_start = 1;
      tick();
      fetch_start = 0; pc_write = 1; pc_next = 16'h1234;
      chk("t6_req", mem_req, 1);
      chk("t6_addr", mem_addr, 16'hFFFE);
      tick();
      pc_write = 0;
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_req", mem_req, 0);
      chk("t6_rst_pc", pc, 16'h0000);
      chk("t6_rst_ir", ir, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      tick();
      tick();
      @(negedge clk);
      chk("t6_pc_after", pc, 16'h0000);
      chk("t6_busy_after", busy, 0);

      chk("sb_empty", exp_ir_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
